// File: rtl/dmem_arbiter_ctrl.sv
// rtl/dmem_arbiter_ctrl.sv - two-port round-robin arbiter and load/store sequencer for word-addressed data memory
module dmem_arbiter_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [1:0]  r0_size,
  input  logic        r0_unsigned,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  output logic        r0_gnt,
  output logic        r0_done,
  output logic [31:0] r0_rdata,
  output logic        r0_err,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [1:0]  r1_size,
  input  logic        r1_unsigned,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r1_gnt,
  output logic        r1_done,
  output logic [31:0] r1_rdata,
  output logic        r1_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t              state_q;
  logic                prio_q;
  logic                own_q;
  logic                we_q;
  logic                uns_q;
  logic [1:0]          size_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [15:0]         wdata_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [31:0]         mem_wd_q;
  logic                r0_done_q, r1_done_q, r0_err_q, r1_err_q;
  logic [31:0]         r0_rdata_q, r1_rdata_q;

  function automatic logic bad_req(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
           (sz == 2'b10 && a[1:0] != 2'b00) || ((a >> (ADDR_W + 2)) != 32'd0);
  endfunction

  // Little-endian lane replace; only byte and half ever reach here.
  function automatic logic [31:0] merge_lane(input logic [31:0] w, input logic [15:0] d,
                                             input logic [1:0] sz, input logic [1:0] a);
    logic [31:0] r;
    r = w;
    if (sz == 2'b00) r[{a, 3'b000} +: 8] = d[7:0];
    else             r[{a[1], 4'b0000} +: 16] = d;
    return r;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                          input logic uns, input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = w[{a[1], 4'b0000} +: 16];
    case (sz)
      2'b00:   return uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  // Port 1 wins only when it is alone or it is its turn.
  logic        pick1, any_req;
  logic        s_we, s_uns, s_err;
  logic [1:0]  s_size;
  logic [31:0] s_addr, s_wdata;

  assign any_req = r0_req | r1_req;
  assign pick1   = r1_req & (~r0_req | prio_q);
  assign s_we    = pick1 ? r1_we       : r0_we;
  assign s_size  = pick1 ? r1_size     : r0_size;
  assign s_uns   = pick1 ? r1_unsigned : r0_unsigned;
  assign s_addr  = pick1 ? r1_addr     : r0_addr;
  assign s_wdata = pick1 ? r1_wdata    : r0_wdata;
  assign s_err   = bad_req(s_size, s_addr);

  assign r0_gnt = rst_n && state_q == IDLE && r0_req && !pick1;
  assign r1_gnt = rst_n && state_q == IDLE && pick1;

  logic        fin_en, fin_own, fin_err;
  logic [31:0] fin_rdata;

  always_comb begin
    fin_en    = 1'b0;
    fin_own   = own_q;
    fin_err   = 1'b0;
    fin_rdata = 32'd0;
    case (state_q)
      IDLE: if (any_req && s_err) begin
        fin_en  = 1'b1;
        fin_own = pick1;
        fin_err = 1'b1;
      end
      RD: if (!we_q) begin
        fin_en    = 1'b1;
        fin_rdata = extract(mem_rd, size_q, uns_q, addr_q[1:0]);
      end
      WR:      fin_en = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      own_q      <= 1'b0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= 16'd0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_wd_q   <= 32'd0;
      r0_done_q  <= 1'b0;
      r1_done_q  <= 1'b0;
      r0_err_q   <= 1'b0;
      r1_err_q   <= 1'b0;
      r0_rdata_q <= 32'd0;
      r1_rdata_q <= 32'd0;
    end else begin
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_wd_q   <= 32'd0;
      r0_done_q  <= 1'b0;
      r1_done_q  <= 1'b0;
      case (state_q)
        IDLE: if (any_req) begin
          own_q   <= pick1;
          prio_q  <= ~pick1;
          we_q    <= s_we;
          uns_q   <= s_uns;
          size_q  <= s_size;
          addr_q  <= s_addr[ADDR_W+1:0];
          wdata_q <= s_wdata[15:0];
          if (s_err) begin
            state_q <= DONE;
          end else if (s_we && s_size == 2'b10) begin
            state_q    <= WR;
            mem_we_q   <= 1'b1;
            mem_addr_q <= s_addr[ADDR_W+1:2];
            mem_wd_q   <= s_wdata;
          end else begin
            state_q    <= RD;
            mem_addr_q <= s_addr[ADDR_W+1:2];
          end
        end
        RD: if (we_q) begin
          state_q    <= WR;
          mem_we_q   <= 1'b1;
          mem_addr_q <= addr_q[ADDR_W+1:2];
          mem_wd_q   <= merge_lane(mem_rd, wdata_q, size_q, addr_q[1:0]);
        end else begin
          state_q <= DONE;
        end
        WR:      state_q <= DONE;
        default: state_q <= IDLE;
      endcase
      if (fin_en) begin
        if (fin_own) begin
          r1_done_q  <= 1'b1;
          r1_err_q   <= fin_err;
          r1_rdata_q <= fin_rdata;
        end else begin
          r0_done_q  <= 1'b1;
          r0_err_q   <= fin_err;
          r0_rdata_q <= fin_rdata;
        end
      end
    end
  end

  assign mem_we   = mem_we_q;
  assign mem_addr = {{(32-ADDR_W){1'b0}}, mem_addr_q};
  assign mem_wd   = mem_wd_q;
  assign r0_done  = r0_done_q;
  assign r1_done  = r1_done_q;
  assign r0_err   = r0_err_q;
  assign r1_err   = r1_err_q;
  assign r0_rdata = r0_rdata_q;
  assign r1_rdata = r1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter_ctrl.sv
// tb/tb_dmem_arbiter_ctrl.sv - scoreboard bench for dmem_arbiter_ctrl with a behavioural data memory
module tb_dmem_arbiter_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r0_req = 0, r0_we = 0, r0_unsigned = 0;
  logic [1:0]  r0_size = 0;
  logic [31:0] r0_addr = 0, r0_wdata = 0;
  logic        r1_req = 0, r1_we = 0, r1_unsigned = 0;
  logic [1:0]  r1_size = 0;
  logic [31:0] r1_addr = 0, r1_wdata = 0;
  logic        r0_gnt, r0_done, r0_err, r1_gnt, r1_done, r1_err, mem_we;
  logic [31:0] r0_rdata, r1_rdata, mem_addr, mem_wd, mem_rd;

  dmem_arbiter_ctrl #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_size(r0_size), .r0_unsigned(r0_unsigned),
    .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_done(r0_done),
    .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_we(r1_we), .r1_size(r1_size), .r1_unsigned(r1_unsigned),
    .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_done(r1_done),
    .r1_rdata(r1_rdata), .r1_err(r1_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  assign mem_rd = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wd;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int port; logic [31:0] rdata; logic err; int cyc; } dexp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; } wexp_t;
  dexp_t dq[$];
  wexp_t wq[$];
  int    gorder[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_port(input int p, input logic req, input logic we, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a, input logic [31:0] wd);
    if (p == 0) begin
      r0_req = req; r0_we = we; r0_size = sz; r0_unsigned = uns; r0_addr = a; r0_wdata = wd;
    end else begin
      r1_req = req; r1_we = we; r1_size = sz; r1_unsigned = uns; r1_addr = a; r1_wdata = wd;
    end
  endtask

  task automatic issue(input int p, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic exp_done, input logic [31:0] erd, input logic eerr, input int dlat,
                       input logic exp_wr, input logic [31:0] widx, input logic [31:0] wdat, input int wlat);
    int t;
    logic got;
    dexp_t d;
    wexp_t w;
    got = 1'b0;
    @(negedge clk);
    set_port(p, 1'b1, we, sz, uns, a, wd);
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      if ((p == 0) ? r0_gnt : r1_gnt) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL grant_timeout port %0d addr %h", p, a);
      set_port(p, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
      return;
    end
    t = cyc;
    gorder.push_back(p);
    if (exp_done) begin
      d.port = p; d.rdata = erd; d.err = eerr; d.cyc = t + dlat;
      dq.push_back(d);
    end
    if (exp_wr) begin
      w.addr = widx; w.data = wdat; w.cyc = t + wlat;
      wq.push_back(w);
    end
    @(posedge clk);
    #1;
    set_port(p, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
  endtask

  // Monitor: pops expectations when the DUT presents done or a write.
  logic inflight = 1'b0;
  always @(negedge clk) begin
    dexp_t d;
    wexp_t w;
    #2;
    if (!rst_n) begin
      inflight = 1'b0;
    end else begin
      if (r0_done || r1_done) begin
        inflight = 1'b0;
        if (dq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done r0=%b r1=%b at cycle %0d", r0_done, r1_done, cyc);
        end else begin
          d = dq.pop_front();
          chk("done_port", {30'd0, r1_done, r0_done}, (d.port == 0) ? 32'd1 : 32'd2);
          chk("done_rdata", (d.port == 0) ? r0_rdata : r1_rdata, d.rdata);
          chk("done_err", {31'd0, (d.port == 0) ? r0_err : r1_err}, {31'd0, d.err});
          chk("done_cycle", cyc, d.cyc);
        end
      end
      if (mem_we) begin
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write addr %h data %h at cycle %0d", mem_addr, mem_wd, cyc);
        end else begin
          w = wq.pop_front();
          chk("wr_addr", mem_addr, w.addr);
          chk("wr_data", mem_wd, w.data);
          chk("wr_cycle", cyc, w.cyc);
        end
      end
      if (r0_gnt || r1_gnt) begin
        if (inflight || (r0_gnt && r1_gnt)) begin
          checks++; errors++;
          $display("FAIL grant_while_busy r0=%b r1=%b at cycle %0d", r0_gnt, r1_gnt, cyc);
        end
        inflight = 1'b1;
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[255] = 32'h1234_5678;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", {30'd0, r1_gnt, r0_gnt}, 32'd0);
    chk("rst_done", {30'd0, r1_done, r0_done}, 32'd0);
    chk("rst_err", {30'd0, r1_err, r0_err}, 32'd0);
    chk("rst_r0_rdata", r0_rdata, 32'd0);
    chk("rst_r1_rdata", r1_rdata, 32'd0);
    chk("rst_mem", {31'd0, mem_we} | mem_addr | mem_wd, 32'd0);
    rst_n = 1'b1;

    // word store then load back
    issue(0, 1, 2'b10, 0, 32'h08, 32'hCAFEBABE, 1, 32'd0, 0, 2, 1, 32'd2, 32'hCAFEBABE, 1);
    issue(0, 0, 2'b10, 0, 32'h08, 32'd0, 1, 32'hCAFEBABE, 0, 2, 0, 0, 0, 0);
    chk("rd_mem_addr", mem_addr, 32'd2);
    // sub-word store and extending loads
    issue(0, 1, 2'b00, 0, 32'h0A, 32'h0000005A, 1, 32'd0, 0, 3, 1, 32'd2, 32'hCA5ABABE, 2);
    issue(0, 0, 2'b00, 0, 32'h0B, 32'd0, 1, 32'hFFFFFFCA, 0, 2, 0, 0, 0, 0);
    issue(0, 0, 2'b00, 1, 32'h0B, 32'd0, 1, 32'h000000CA, 0, 2, 0, 0, 0, 0);
    issue(0, 0, 2'b01, 0, 32'h0A, 32'd0, 1, 32'hFFFFCA5A, 0, 2, 0, 0, 0, 0);
    issue(0, 0, 2'b01, 1, 32'h08, 32'd0, 1, 32'h0000BABE, 0, 2, 0, 0, 0, 0);
    // errors: misalignment, illegal size, out of range
    issue(0, 0, 2'b10, 0, 32'h06, 32'd0, 1, 32'd0, 1, 1, 0, 0, 0, 0);
    issue(0, 1, 2'b01, 0, 32'h03, 32'hFFFF, 1, 32'd0, 1, 1, 0, 0, 0, 0);
    issue(1, 0, 2'b11, 0, 32'h00, 32'd0, 1, 32'd0, 1, 1, 0, 0, 0, 0);
    issue(1, 1, 2'b11, 0, 32'h04, 32'h1, 1, 32'd0, 1, 1, 0, 0, 0, 0);
    issue(0, 0, 2'b10, 0, 32'h400, 32'd0, 1, 32'd0, 1, 1, 0, 0, 0, 0);
    issue(0, 0, 2'b10, 0, 32'h3FC, 32'd0, 1, 32'h12345678, 0, 2, 0, 0, 0, 0);
    chk("top_mem_addr", mem_addr, 32'd255);
    // sub-word store on port 1
    issue(1, 1, 2'b01, 0, 32'h0E, 32'h0000BEEF, 1, 32'd0, 0, 3, 1, 32'd3, 32'hBEEF0000, 2);

    // reset, then both ports contend
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    gorder.delete();
    fork
      begin
        issue(0, 0, 2'b10, 0, 32'h08, 32'd0, 1, 32'hCA5ABABE, 0, 2, 0, 0, 0, 0);
        issue(0, 0, 2'b10, 0, 32'h3FC, 32'd0, 1, 32'h12345678, 0, 2, 0, 0, 0, 0);
      end
      begin
        issue(1, 0, 2'b10, 0, 32'h0C, 32'd0, 1, 32'hBEEF0000, 0, 2, 0, 0, 0, 0);
        issue(1, 0, 2'b00, 1, 32'h0F, 32'd0, 1, 32'h000000BE, 0, 2, 0, 0, 0, 0);
      end
    join
    chk("grant_count", gorder.size(), 32'd4);
    if (gorder.size() == 4) begin
      chk("grant_order", {gorder[0][7:0], gorder[1][7:0], gorder[2][7:0], gorder[3][7:0]}, 32'h00010001);
    end
    repeat (4) @(negedge clk);
    chk("hold_r0_rdata", r0_rdata, 32'h12345678);
    chk("hold_r1_rdata", r1_rdata, 32'h000000BE);

    // reset while a byte store sits in RD
    issue(0, 1, 2'b00, 0, 32'h08, 32'h00000011, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_mem_word", mem[2], 32'hCA5ABABE);
    chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
    rst_n = 1'b1;
    issue(1, 0, 2'b10, 0, 32'h08, 32'd0, 1, 32'hCA5ABABE, 0, 2, 0, 0, 0, 0);

    for (int i = 0; i < 20 && (dq.size() != 0 || wq.size() != 0); i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("pending_done", dq.size(), 32'd0);
    chk("pending_write", wq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter_ctrl.md
Name: dmem_arbiter_ctrl

Overview:
Sequencing controller and two-port arbiter in front of the word-addressed data memory (combinational read, write on posedge when we=1).
Accepts byte/half/word loads and stores from two requesters: port 0 = core LSU, port 1 = debug/DMA.
Round-robin arbitration between them.
Translates byte addresses to word indices, does read-modify-write for sub-word stores, and extracts/extends load data.
Sits between the core's memory stage and the data memory instance.

Parameters:
ADDR_W, 8, memory word-index width (2^ADDR_W words); mem_addr width.

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  reset, synchronous, active-low
r0_req  in  1  port 0 request valid; held with stable fields until r0_gnt
r0_we  in  1  1=store, 0=load
r0_size  in  2  00 byte, 01 half, 10 word, 11 illegal
r0_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend
r0_addr  in  32  byte address
r0_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
r0_gnt  out  1  combinational accept strobe
r0_done  out  1  one-cycle completion pulse
r0_rdata  out  32  load result, valid with r0_done
r0_err  out  1  error flag, valid with r0_done
r1_*  same set as r0_* for port 1
mem_we  out  1  data memory write enable
mem_addr  out  32  word index; bits [31:ADDR_W] always 0
mem_wd  out  32  data memory write data
mem_rd  in  32  data memory read data (combinational from mem_addr)

Behaviour:
Clock and reset: one clock; reset is synchronous and active-low.

Reset values:
- state=IDLE, rr pointer favours port 0.
- All outputs 0: gnt, done, rdata, err, mem_we, mem_addr, mem_wd.
- Reset asserted mid-transaction aborts it: no write, no done, and mem_we=0 from the reset edge.

FSM states: IDLE, RD, WR, DONE.

IDLE:
- If any req is high, grant one port: gnt high combinationally this cycle, and the transaction is latched at the edge.
- Both requesting: grant the port not served last. After reset, port 0 wins.
- Single requester: always granted.
- The requester must drop or change req in the cycle after gnt.
- Error check on latched fields:
  - size=11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr[31:ADDR_W+2]!=0 (out of range).
- Error -> DONE with err=1 and no memory access.
- Otherwise: load or sub-word store -> RD; word store -> WR.

RD:
- mem_addr = addr[ADDR_W+1:2]; capture mem_rd into an internal word buffer.
- Load -> DONE. Sub-word store -> WR.

WR:
- mem_we=1, mem_addr as in RD.
- mem_wd = full wdata for a word store, otherwise the buffer with the target lane replaced (little-endian):
  - byte lane = addr[1:0];
  - half lane = addr[1].
- Next state DONE.

DONE:
- The owning port's done=1 for exactly one cycle.
- rdata for loads:
  - byte/half from lane addr[1:0] / addr[1], extended per unsigned;
  - word passed through.
- rdata=0 for stores and errors.
- rdata/err hold until the next done on that port.
- Next state IDLE.
- req is ignored in RD, WR and DONE.

Latency, with grant at cycle T:
- load: done at T+2;
- word store: write at T+1, done at T+2;
- sub-word store: write at T+2, done at T+3;
- error: done at T+1.

mem_we is high only in WR. mem_addr/mem_wd are 0 in IDLE and DONE.

Test Plan:
1. r0 word store addr 0x08, data CAFEBABE -> at T+1 mem_we=1, mem_addr=2, mem_wd=CAFEBABE; r0_done at T+2. A load of 0x08 then returns rdata=CAFEBABE at T+2.
2. With word 2=CAFEBABE: sb addr 0x0A, wdata 0x0000005A -> write at T+2 of CA5ABABE. Then:
   - lb 0x0B -> FFFFFFCA;
   - lbu 0x0B -> 000000CA;
   - lh 0x0A -> FFFFCA5A.
3. lw 0x06 and sh 0x03 -> err=1 at T+1, rdata=0, mem_we never asserted. size=11 -> err=1 likewise.
4. ADDR_W=8, lw 0x400 -> err=1; lw 0x3FC -> mem_addr=255, no error.
5. Both ports request every cycle after reset -> grant order r0, r1, r0, r1. Each done goes only to its owner; no grant while busy.
6. rst_n=0 during RD of an sb -> memory word unchanged, no done, state IDLE. The next request is granted normally.
